// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment driver: cycles the anodes, decodes BCD digits
// from a per-frame shadow copy of the inputs, and blanks leading zeros when asked to.
module seven_seg_scanner #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] thousands,
   input  logic [3:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   input  logic [3:0] dp_in,
   input  logic       blank_en,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   localparam int             CW     = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]  TC_VAL = CW'(REFRESH_DIV - 1);
   localparam logic [6:0]     SEG_OFF  = 7'b1111111;
   localparam logic [6:0]     SEG_DASH = 7'b0111111;

   logic [CW-1:0]   r_presc;
   logic [1:0]      r_idx;
   logic [3:0][3:0] r_sh_dig;
   logic [3:0]      r_sh_dp;
   logic            r_sh_blank;
   logic            r_frame_tick;
   logic [3:0]      r_an;
   logic [6:0]      r_seg;
   logic            r_dp;

   logic            w_tc;
   logic            w_frame_end;
   logic [3:1]      w_nz;
   logic [3:0]      w_blank;
   logic [3:0][6:0] w_seg_dig;

   function automatic logic [6:0] f_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   assign w_tc        = (r_presc == TC_VAL);
   assign w_frame_end = w_tc && (r_idx == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_idx   <= 2'd0;
      end else begin
         r_presc <= w_tc ? '0 : r_presc + 1'b1;
         if (w_tc) begin
            r_idx <= r_idx + 2'd1;
         end
      end
   end

   // Inputs are sampled only at the frame boundary so a frame never mixes old and new values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_dig     <= '0;
         r_sh_dp      <= 4'b0000;
         r_sh_blank   <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_frame_end;
         if (w_frame_end) begin
            r_sh_dig   <= {thousands, hundreds, tens, ones};
            r_sh_dp    <= dp_in;
            r_sh_blank <= blank_en;
         end
      end
   end

   // A digit is blanked only while it and every more-significant digit are zero.
   assign w_blank[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < 4; gi++) begin : g_blank
         assign w_nz[gi]    = (r_sh_dig[gi] != 4'd0);
         assign w_blank[gi] = r_sh_blank & ~(|w_nz[3:gi]);
      end
      for (gi = 0; gi < 4; gi++) begin : g_decode
         assign w_seg_dig[gi] = w_blank[gi] ? SEG_OFF : f_decode(r_sh_dig[gi]);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an  <= 4'b1111;
         r_seg <= SEG_OFF;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= ~(4'b0001 << r_idx);
         r_seg <= w_seg_dig[r_idx];
         r_dp  <= ~r_sh_dp[r_idx];
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner at REFRESH_DIV=4: expected digit displays are
// queued at each frame_tick and a negedge monitor pops one per anode change.
module tb_seven_seg_scanner;

   logic       clk;
   logic       rst_n;
   logic [3:0] thousands, hundreds, tens, ones;
   logic [3:0] dp_in;
   logic       blank_en;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;

   int errors = 0;
   int checks = 0;

   seven_seg_scanner #(.REFRESH_DIV(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .thousands  (thousands),
      .hundreds   (hundreds),
      .tens       (tens),
      .ones       (ones),
      .dp_in      (dp_in),
      .blank_en   (blank_en),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      int         tag;
   } exp_t;

   exp_t exp_q[$];

   typedef struct {
      logic [3:0] th, hu, te, on, dpi;
      logic       ben;
      logic [6:0] s3, s2, s1, s0;
      logic [3:0] edp;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b required %b", name, got, want);
      end
   endtask

   task automatic push_frame(input int tag, input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] edp);
      exp_q.push_back('{an: 4'b1110, seg: s0, dp: edp[0], tag: tag});
      exp_q.push_back('{an: 4'b1101, seg: s1, dp: edp[1], tag: tag});
      exp_q.push_back('{an: 4'b1011, seg: s2, dp: edp[2], tag: tag});
      exp_q.push_back('{an: 4'b0111, seg: s3, dp: edp[3], tag: tag});
   endtask

   task automatic wait_tick(input string name);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!frame_tick && n < 40);
      checks++;
      if (!frame_tick) begin
         errors++;
         $display("FAIL %s: frame_tick not seen within 40 cycles", name);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 16'(exp_q.size()), 16'd0);
   endtask

   // Monitor: one queued record per new anode value; dwell must be steady.
   initial begin
      logic [3:0] prev_an;
      logic [6:0] prev_seg;
      logic       prev_dp;
      exp_t       e;
      prev_an = 4'b1111; prev_seg = 7'h7F; prev_dp = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (an !== prev_an) begin
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  checks++;
                  if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                     errors++;
                     $display("FAIL frame%0d_digit: got an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                              e.tag, an, seg, dp, e.an, e.seg, e.dp);
                  end else begin
                     $display("frame%0d an=%b seg=%b dp=%b ok", e.tag, an, seg, dp);
                  end
               end
            end else begin
               check("steady_dwell", {8'd0, seg, dp}, {8'd0, prev_seg, prev_dp});
            end
         end
         prev_an = an; prev_seg = seg; prev_dp = dp;
      end
   end

   initial begin
      logic [3:0] scan_pat [4];
      scan_pat[0] = 4'b1110; scan_pat[1] = 4'b1101; scan_pat[2] = 4'b1011; scan_pat[3] = 4'b0111;

      //            th    hu    te    on    dp_in    ben   thou        hund        tens        ones        ~dp
      vecs[0] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'b0000, 1'b0, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111};
      vecs[1] = '{4'd0, 4'd0, 4'd7, 4'd0, 4'b0000, 1'b1, 7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000, 4'b1111};
      vecs[2] = '{4'd0, 4'd0, 4'd7, 4'd0, 4'b0000, 1'b0, 7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000, 4'b1111};
      vecs[3] = '{4'd0, 4'd0, 4'd0, 4'd12,4'b0001, 1'b1, 7'b1111111, 7'b1111111, 7'b1111111, 7'b0111111, 4'b1110};
      vecs[4] = '{4'd15,4'd0, 4'd0, 4'd5, 4'b1010, 1'b1, 7'b0111111, 7'b1000000, 7'b1000000, 7'b0010010, 4'b0101};
      vecs[5] = '{4'd0, 4'd9, 4'd0, 4'd8, 4'b0100, 1'b1, 7'b1111111, 7'b0010000, 7'b1000000, 7'b0000000, 4'b1011};
      vecs[6] = '{4'd0, 4'd0, 4'd6, 4'd0, 4'b1111, 1'b1, 7'b1111111, 7'b1111111, 7'b0000010, 7'b1000000, 4'b0000};
      vecs[7] = '{4'd0, 4'd10,4'd0, 4'd3, 4'b0000, 1'b1, 7'b1111111, 7'b0111111, 7'b1000000, 7'b0110000, 4'b1111};

      rst_n = 1'b0;
      thousands = 4'd4; hundreds = 4'd3; tens = 4'd2; ones = 4'd1; dp_in = 4'b0000; blank_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_an", 16'(an), 16'(4'b1111));
      check("reset_seg", 16'(seg), 16'(7'b1111111));
      check("reset_dp_tick", {14'd0, dp, frame_tick}, 16'b10);

      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("first_seg", 16'(seg), 16'(7'b1000000));
      $display("scan cycle 1 an=%b seg=%b", an, seg);
      check("scan_an_c1", 16'(an), 16'(scan_pat[0]));
      check("scan_tick_c1", 16'(frame_tick), 16'd0);
      for (int c = 2; c <= 32; c++) begin
         @(posedge clk); #1;
         check($sformatf("scan_an_c%0d", c), 16'(an), 16'(scan_pat[((c - 1) / 4) % 4]));
         check($sformatf("scan_tick_c%0d", c), 16'(frame_tick), 16'((c % 16) == 0));
      end

      // Each vector is applied just after a frame boundary, so the frame on screen
      // while it is applied must still show the previously latched values.
      for (int i = 0; i < 8; i++) begin
         thousands = vecs[i].th; hundreds = vecs[i].hu; tens = vecs[i].te; ones = vecs[i].on;
         dp_in = vecs[i].dpi; blank_en = vecs[i].ben;
         wait_tick($sformatf("tick_vec%0d", i));
         push_frame(i, vecs[i].s3, vecs[i].s2, vecs[i].s1, vecs[i].s0, vecs[i].edp);
      end
      drain("drain_vectors");

      repeat (6) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_an", 16'(an), 16'(4'b1111));
      check("midreset_seg", 16'(seg), 16'(7'b1111111));
      check("midreset_dp_tick", {14'd0, dp, frame_tick}, 16'b10);
      repeat (2) @(posedge clk);
      @(negedge clk);
      push_frame(100, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111);
      rst_n = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("restart_an_c%0d", c), 16'(an), 16'(scan_pat[(c - 1) / 4]));
      end
      drain("drain_restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clock cycles each digit is lit; legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports thousands, hundreds, tens, ones, input, 4 each: BCD digits from the upstream binary-to-BCD converter.
REQ-005 SHALL have port dp_in, input, 4: per-digit decimal point request, active-high; bit0 = ones.
REQ-006 SHALL have port blank_en, input, 1: leading-zero blanking enable.
REQ-007 SHALL have port an, output, 4: digit anodes, active-low; an[0] = ones, an[3] = thousands.
REQ-008 SHALL have port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port dp, output, 1: decimal point, active-low.
REQ-010 SHALL have port frame_tick, output, 1: one-cycle pulse at each frame boundary.

Function
REQ-011 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; terminal count (tc) = count equals REFRESH_DIV-1.
REQ-012 Digit index idx (2 bits) SHALL increment on tc, in the order 0,1,2,3,0.
REQ-013 On tc with idx==3, the block SHALL latch thousands/hundreds/tens/ones/dp_in/blank_en into shadow registers and pulse frame_tick high for exactly that following cycle.
REQ-014 Between shadow loads, input changes SHALL have no effect on the outputs (no tearing within a frame).
REQ-015 an, seg and dp SHALL be registered, computed from the current idx and shadow values, so they lag idx/shadow by one cycle.
REQ-016 an SHALL drive exactly one bit low: the bit at position idx. All other bits SHALL be high.
REQ-017 Encoding of seg (active-low) SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-018 A shadow digit of 10..15 SHALL display dash 0111111 and SHALL count as non-zero for blanking.
REQ-019 With shadow blank_en=1, leading-zero blanking SHALL apply:
- thousands blanked if it is 0
- hundreds blanked if thousands and hundreds are 0
- tens blanked if thousands, hundreds and tens are 0
- ones never blanked
REQ-020 A blanked digit SHALL output seg=1111111; an still scans normally.
REQ-021 dp SHALL equal the inverse of shadow dp_in[idx], independent of blanking.
REQ-022 A new input value SHALL be visible no later than 4*REFRESH_DIV+1 cycles after it is stable.

Reset
REQ-023 While rst_n=0, the following SHALL hold:
- prescaler=0, idx=0
- shadow digits=0, shadow dp_in=0, shadow blank_en=0
- an=1111, seg=1111111, dp=1, frame_tick=0
REQ-024 Reset assertion mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-025 On the first clock edge after reset release, an SHALL become 1110 and seg 1000000 (shadow zero); the first shadow load SHALL occur at the first tc with idx==3.

Verification (REFRESH_DIV=4)
REQ-026 Scan order: after reset release, an SHALL step 1110, 1101, 1011, 0111 and repeat, with each step lasting 4 cycles; frame_tick SHALL pulse once per 16 cycles.
REQ-027 Digits: with inputs 1,2,3,4 held, after the first frame_tick the display SHALL be:
- an=0111 with seg=0011001 (digit 4)
- an=1011 with seg=0110000 (digit 3)
- an=1101 with seg=0100100 (digit 2)
- an=1110 with seg=1111001 (digit 1)
REQ-028 Blanking: with inputs 0,0,7,0 and blank_en=1, thousands and hundreds SHALL show 1111111, tens 1111000 and ones 1000000; with blank_en=0, all four digits SHALL be shown.
REQ-029 Invalid digit and dp: with ones=12 and dp_in=0001, ones SHALL show 0111111 with dp=0; other digits SHALL have dp=1.
REQ-030 No tearing: inputs changed mid-frame SHALL leave the outputs unchanged until the cycle after the next frame_tick.
REQ-031 Mid-frame reset: asserting rst_n=0 mid-frame SHALL drive an=1111, seg=1111111 and dp=1 before the next clock edge; after release, scanning SHALL restart from an=1110.
